// File: rtl/change_pkg.sv
// change_pkg: shared state encoding, coin values and default sizing for the change dispenser
package change_pkg;
  localparam int NDEN_DEF = 5;
  localparam int AMT_W_DEF = 9;
  localparam int CENT_B = 100;
  localparam int CENT_Q = 25;
  localparam int CENT_D = 10;
  localparam int CENT_N = 5;
  localparam int CENT_P = 1;
  localparam logic [NDEN_DEF-1:0][AMT_W_DEF-1:0] DENOM_DEF = {
    AMT_W_DEF'(CENT_B), AMT_W_DEF'(CENT_Q), AMT_W_DEF'(CENT_D), AMT_W_DEF'(CENT_N), AMT_W_DEF'(CENT_P)
  };
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DISPENSE = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  typedef enum logic [1:0] {IDLE = ST_IDLE, DISPENSE = ST_DISPENSE, DONE = ST_DONE} state_t;
endpackage

// File: rtl/change_dispenser_coin_select.sv
// coin_select: one-hot pick of the largest available denomination that fits in the amount owed
module coin_select
  import change_pkg::*;
#(
  parameter int NDEN = NDEN_DEF,
  parameter int AMT_W = AMT_W_DEF,
  parameter logic [NDEN-1:0][AMT_W-1:0] DENOM_VAL = DENOM_DEF
) (
  input  logic [NDEN-1:0]  avail,
  input  logic [AMT_W-1:0] remaining,
  output logic [NDEN-1:0]  sel,
  output logic             sel_valid
);
  // scan upward so the highest fitting index is the one left standing
  always_comb begin
    sel = '0;
    sel_valid = 1'b0;
    for (int k = 0; k < NDEN; k++)
      if (avail[k] && DENOM_VAL[k] <= remaining) begin
        sel = NDEN'(1) << k;
        sel_valid = 1'b1;
      end
  end
endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: greedy coin-by-coin change dispenser; CHANGE_DISPENSER_ACK_EN holds each coin until acknowledged
module change_dispenser
  import change_pkg::*;
#(
  parameter int NDEN = NDEN_DEF,
  parameter int AMT_W = AMT_W_DEF,
  parameter logic [NDEN-1:0][AMT_W-1:0] DENOM_VAL = DENOM_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  input  logic [NDEN-1:0]  avail,
  input  logic             disp_ack,
  output logic [NDEN-1:0]  disp,
  output logic             done,
  output logic             short_chg,
  output logic [AMT_W-1:0] remaining,
  output logic [AMT_W-1:0] coin_cnt
);
  state_t state;
  logic [NDEN-1:0] sel, cur;
  logic sel_valid, fits, take, decide;
  logic [AMT_W-1:0] coin_val;
  coin_select #(.NDEN(NDEN), .AMT_W(AMT_W), .DENOM_VAL(DENOM_VAL)) u_sel (
    .avail(avail),
    .remaining(remaining),
    .sel(sel),
    .sel_valid(sel_valid)
  );
  assign fits = state == DISPENSE && remaining != '0 && sel_valid;
`ifdef CHANGE_DISPENSER_ACK_EN
  logic [NDEN-1:0] held;
  logic held_v, gap;
  assign cur = held_v ? held : (fits && !gap ? sel : '0);
  assign take = disp_ack && |cur;
  assign decide = !held_v && !gap;
  // latch the presented coin so avail cannot disturb it; idle one cycle after each ack
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      held <= '0;
      held_v <= 1'b0;
      gap <= 1'b0;
    end else begin
      gap <= take;
      held_v <= take ? 1'b0 : (|cur ? 1'b1 : held_v);
      held <= |cur ? cur : held;
    end
`else
  logic unused_ack;
  assign unused_ack = disp_ack;
  assign cur = fits ? sel : '0;
  assign take = |cur;
  assign decide = 1'b1;
`endif
  assign disp = cur;
  // value of the coin currently presented
  always_comb begin
    coin_val = '0;
    for (int k = 0; k < NDEN; k++)
      coin_val = coin_val | (cur[k] ? DENOM_VAL[k] : '0);
  end
  // transaction control: accept, subtract per coin, finish when paid or stuck
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      done <= 1'b0;
      short_chg <= 1'b0;
      remaining <= '0;
      coin_cnt <= '0;
    end else if (start && state != DISPENSE) begin
      state <= DISPENSE;
      done <= 1'b0;
      short_chg <= 1'b0;
      remaining <= amount;
      coin_cnt <= '0;
    end else if (state == DISPENSE) begin
      if (take) begin
        remaining <= remaining - coin_val;
        coin_cnt <= &coin_cnt ? coin_cnt : coin_cnt + 1'b1;
      end else if (decide && cur == '0) begin
        done <= 1'b1;
        short_chg <= remaining != '0;
        state <= DONE;
      end
    end
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed scoreboard bench for change_dispenser
module tb_change_dispenser;
  import change_pkg::*;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, disp_ack = 1'b0;
  logic [8:0] amount = '0;
  logic [4:0] avail = '0;
  logic [4:0] disp;
  logic done, short_chg;
  logic [8:0] remaining, coin_cnt;
  int n_cmp = 0, n_bad = 0;
  logic [4:0] exp_q[$];
  always #5 clk = ~clk;
  change_dispenser dut (
    .clk(clk), .reset(reset), .start(start), .amount(amount), .avail(avail), .disp_ack(disp_ack),
    .disp(disp), .done(done), .short_chg(short_chg), .remaining(remaining), .coin_cnt(coin_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic start_txn(input int amt, input logic [4:0] av);
    amount = 9'(amt);
    avail = av;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic run_txn(input string tag, input int lat);
    int c = 0;
    while (!done && c < 100) begin
      if (disp != '0) chk({tag, "_coin"}, disp, exp_q.size() != 0 ? exp_q.pop_front() : 5'd0);
      @(negedge clk);
      c++;
    end
    chk({tag, "_lat"}, c, lat);
    chk({tag, "_left"}, exp_q.size(), 0);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_disp"}, disp, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_short"}, short_chg, 0);
    chk({tag, "_rem"}, remaining, 0);
    chk({tag, "_cnt"}, coin_cnt, 0);
    chk({tag, "_state"}, dut.state, IDLE);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (2) @(negedge clk);
    chk_zero("rst");
    reset = 1'b0;
`ifndef CHANGE_DISPENSER_ACK_EN
    exp_q = '{5'd16, 5'd8, 5'd4, 5'd2, 5'd1};
    start_txn(141, 5'b11111);
    run_txn("c141", 6);
    chk("c141_cnt", coin_cnt, 5);
    chk("c141_short", short_chg, 0);
    chk("c141_rem", remaining, 0);
    avail = '0;
    repeat (3) @(negedge clk);
    chk("hold_done", done, 1);
    chk("hold_cnt", coin_cnt, 5);
    chk("hold_disp", disp, 0);
    exp_q = '{5'd4, 5'd4, 5'd4, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1};
    start_txn(37, 5'b00101);
    run_txn("c37", 11);
    chk("c37_cnt", coin_cnt, 10);
    chk("c37_short", short_chg, 0);
    exp_q = '{5'd8};
    start_txn(30, 5'b01000);
    run_txn("c30", 2);
    chk("c30_short", short_chg, 1);
    chk("c30_rem", remaining, 5);
    chk("c30_cnt", coin_cnt, 1);
    start_txn(0, 5'b11111);
    chk("c0_early_done", done, 0);
    chk("c0_disp", disp, 0);
    run_txn("c0", 1);
    chk("c0_cnt", coin_cnt, 0);
    chk("c0_short", short_chg, 0);
    start_txn(10, 5'b11111);
    chk("ign_coin", disp, 4);
    amount = 9'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ign_rem", remaining, 0);
    chk("ign_done", done, 0);
    run_txn("ign", 1);
    chk("ign_cnt", coin_cnt, 1);
    start_txn(141, 5'b11111);
    chk("r_coin1", disp, 16);
    @(negedge clk);
    chk("r_coin2", disp, 8);
    @(negedge clk);
    chk("r_coin3", disp, 4);
    #1 reset = 1'b1;
    #1 chk_zero("rmid");
    @(negedge clk);
    reset = 1'b0;
    exp_q = '{5'd2};
    start_txn(5, 5'b11111);
    run_txn("r5", 2);
    chk("r5_cnt", coin_cnt, 1);
`else
    start_txn(26, 5'b11111);
    chk("a_q0", disp, 8);
    @(negedge clk);
    chk("a_q1", disp, 8);
    avail = 5'b00001;
    @(negedge clk);
    chk("a_q2", disp, 8);
    disp_ack = 1'b1;
    @(negedge clk);
    disp_ack = 1'b0;
    chk("a_gap1", disp, 0);
    chk("a_rem1", remaining, 1);
    chk("a_cnt1", coin_cnt, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("a_p", disp, 1);
    end
    disp_ack = 1'b1;
    @(negedge clk);
    disp_ack = 1'b0;
    chk("a_gap2", disp, 0);
    run_txn("a26", 2);
    chk("a_cnt", coin_cnt, 2);
    chk("a_rem", remaining, 0);
    chk("a_short", short_chg, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
